llc_bus_initiator: RTL and testbench

Issues LLC bus operations (READ, WRITE, INVALIDATE, RFO) on behalf of the LLC controller and collects snoop results from every peer cache. Aggregates the results, waits for a peer's writeback when a line is held modified elsewhere, and returns the MESI state to install. Sits between the LLC miss/eviction path and the shared snoop bus, opposite the per-cache snooped-read responders.

---
 rtl/cache_define_pkg.sv | 61 ++++++
 rtl/llc_bus_initiator_collector.sv | 67 ++++++
 rtl/llc_bus_initiator.sv | 145 ++++++++++++++
 tb/tb_llc_bus_initiator.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_define_pkg.sv
// Shared encodings for the LLC bus initiator: bus operations, snoop results,
// MESI install states, the initiator FSM states and small decode helpers.
package cache_define;

  typedef enum logic [1:0] {
    OP_READ       = 2'd0,
    OP_WRITE      = 2'd1,
    OP_INVALIDATE = 2'd2,
    OP_RFO        = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    SNP_HIT   = 2'd0,
    SNP_HITM  = 2'd1,
    SNP_NOHIT = 2'd2
  } snoop_result_t;

  typedef enum logic [1:0] {
    MESI_M = 2'd0,
    MESI_E = 2'd1,
    MESI_S = 2'd2,
    MESI_I = 2'd3
  } mesi_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_WAIT_WB = 3'd3,
    ST_RESP    = 3'd4
  } init_state_t;

  // Priority merge of two snoop results: HITM beats HIT beats NOHIT.
  // The unused encoding 2'd3 is treated as NOHIT.
  function automatic snoop_result_t snoop_merge(input snoop_result_t a,
                                                input snoop_result_t b);
    snoop_result_t r;
    if (a == SNP_HITM || b == SNP_HITM) begin
      r = SNP_HITM;
    end else if (a == SNP_HIT || b == SNP_HIT) begin
      r = SNP_HIT;
    end else begin
      r = SNP_NOHIT;
    end
    return r;
  endfunction

  // MESI state the LLC installs for a given operation and aggregate result.
  function automatic mesi_t install_state(input bus_op_t op,
                                          input snoop_result_t agg);
    mesi_t m;
    case (op)
      OP_READ:       m = (agg == SNP_NOHIT) ? MESI_E : MESI_S;
      OP_RFO:        m = MESI_M;
      OP_INVALIDATE: m = MESI_M;
      default:       m = MESI_I;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/llc_bus_initiator_collector.sv
// Snoop result collector: tracks which peers have answered, folds their
// results into one aggregate and counts COLLECT cycles toward the timeout.
// done/agg/timed_out include strobes arriving in the current cycle so the
// owner can register the final answer on the exit edge.
module llc_snoop_collector
  import cache_define::*;
#(
  parameter int N_SNOOPERS    = 3,
  parameter int SNOOP_TIMEOUT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [N_SNOOPERS-1:0]     snp_valid,
  input  logic [2*N_SNOOPERS-1:0]   snp_result,
  output logic                      done,
  output snoop_result_t             agg,
  output logic                      timed_out
);

  localparam int CNT_W = $clog2(SNOOP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SNOOP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [N_SNOOPERS-1:0] mask;
  logic [N_SNOOPERS-1:0] new_hits;
  logic [N_SNOOPERS-1:0] mask_next;
  snoop_result_t         agg_q;
  snoop_result_t         agg_next;
  logic [CNT_W-1:0]      cnt;

  // Fold first-time strobes of this cycle into the running mask/aggregate.
  always_comb begin
    new_hits  = snp_valid & ~mask & {N_SNOOPERS{enable}};
    mask_next = mask | new_hits;
    agg_next  = agg_q;
    for (int i = 0; i < N_SNOOPERS; i++) begin
      if (new_hits[i]) begin
        agg_next = snoop_merge(agg_next, snoop_result_t'(snp_result[2*i +: 2]));
      end
    end
    done      = enable && ((&mask_next) || (cnt == CNT_LAST));
    agg       = agg_next;
    timed_out = ~(&mask_next);
  end

  // Mask, aggregate and saturating cycle counter; clear starts a new operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask  <= '0;
      agg_q <= SNP_NOHIT;
      cnt   <= '0;
    end else if (clear) begin
      mask  <= '0;
      agg_q <= SNP_NOHIT;
      cnt   <= '0;
    end else if (enable) begin
      mask  <= mask_next;
      agg_q <= agg_next;
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/llc_bus_initiator.sv
// LLC bus initiator: accepts one request from the LLC controller, strobes it
// onto the snoop bus, gathers peer snoop results (waiting for a writeback when
// a peer holds the line modified) and returns the MESI state to install.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. The response fields stay stable while
// rsp_valid is high and rsp_ready is low.
module llc_bus_initiator
  import cache_define::*;
#(
  parameter int N_SNOOPERS    = 3,
  parameter int ADDR_W        = 32,
  parameter int SNOOP_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    bus_valid,
  output logic [1:0]              bus_op,
  output logic [ADDR_W-1:0]       bus_addr,
  input  logic [N_SNOOPERS-1:0]   snp_valid,
  input  logic [2*N_SNOOPERS-1:0] snp_result,
  input  logic                    wb_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_mesi,
  output logic [1:0]              rsp_snoop,
  output logic                    rsp_timeout
);

  init_state_t   state;
  init_state_t   state_next;
  bus_op_t       op_q;
  logic [ADDR_W-1:0] addr_q;
  mesi_t         mesi_q;
  snoop_result_t snoop_q;
  logic          timeout_q;

  logic          accept;
  logic          col_clear;
  logic          col_enable;
  logic          col_done;
  snoop_result_t col_agg;
  logic          col_timed_out;
  logic          col_exit;

  assign accept     = (state == ST_IDLE) && req_valid;
  assign col_clear  = accept;
  assign col_enable = (state == ST_COLLECT);
  assign col_exit   = (state == ST_COLLECT) && col_done;

  llc_snoop_collector #(
    .N_SNOOPERS    (N_SNOOPERS),
    .SNOOP_TIMEOUT (SNOOP_TIMEOUT)
  ) u_collector (
    .clk        (clk),
    .rst        (rst),
    .clear      (col_clear),
    .enable     (col_enable),
    .snp_valid  (snp_valid),
    .snp_result (snp_result),
    .done       (col_done),
    .agg        (col_agg),
    .timed_out  (col_timed_out)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a modified line elsewhere on a read-type op must be
  // written back before the line can be installed.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (col_done) begin
          if (col_agg == SNP_HITM && (op_q == OP_READ || op_q == OP_RFO)) begin
            state_next = ST_WAIT_WB;
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_WAIT_WB: begin
        if (wb_done) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request latch; drives the bus operation fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_READ;
      addr_q <= '0;
    end else if (accept) begin
      op_q   <= bus_op_t'(req_op);
      addr_q <= req_addr;
    end
  end

  // Response registers, captured on the edge that leaves COLLECT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mesi_q    <= MESI_I;
      snoop_q   <= SNP_NOHIT;
      timeout_q <= 1'b0;
    end else if (col_exit) begin
      mesi_q    <= install_state(op_q, col_agg);
      snoop_q   <= col_agg;
      timeout_q <= col_timed_out;
    end
  end

  assign req_ready   = (state == ST_IDLE);
  assign bus_valid   = (state == ST_ISSUE);
  assign bus_op      = op_q;
  assign bus_addr    = addr_q;
  assign rsp_valid   = (state == ST_RESP);
  assign rsp_mesi    = mesi_q;
  assign rsp_snoop   = snoop_q;
  assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_llc_bus_initiator.sv
// Directed bench for llc_bus_initiator with hand-computed expectations.
module tb_llc_bus_initiator;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int TO = 8;

  // Encodings written out by hand.
  localparam logic [1:0] READ = 2'd0, WRITE = 2'd1, INVAL = 2'd2, RFO = 2'd3;
  localparam logic [1:0] HIT = 2'd0, HITM = 2'd1, NOHIT = 2'd2;
  localparam logic [1:0] M = 2'd0, E = 2'd1, S = 2'd2, I = 2'd3;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic          bus_valid;
  logic [1:0]    bus_op;
  logic [AW-1:0] bus_addr;
  logic [N-1:0]  snp_valid;
  logic [2*N-1:0] snp_result;
  logic          wb_done;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_mesi;
  logic [1:0]    rsp_snoop;
  logic          rsp_timeout;

  int n_assert;
  int n_fail;

  llc_bus_initiator #(
    .N_SNOOPERS    (N),
    .ADDR_W        (AW),
    .SNOOP_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .bus_valid   (bus_valid),
    .bus_op      (bus_op),
    .bus_addr    (bus_addr),
    .snp_valid   (snp_valid),
    .snp_result  (snp_result),
    .wb_done     (wb_done),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_mesi    (rsp_mesi),
    .rsp_snoop   (rsp_snoop),
    .rsp_timeout (rsp_timeout)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, check the bus strobe, return in the first COLLECT cycle.
  task automatic issue(input string tag, input logic [1:0] op, input logic [AW-1:0] addr);
    chk({tag, ".req_ready"}, req_ready, 1);
    req_op    = op;
    req_addr  = addr;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
    chk({tag, ".bus_valid"}, bus_valid, 1);
    chk({tag, ".bus_op"}, bus_op, op);
    chk({tag, ".bus_addr"}, bus_addr, addr);
    chk({tag, ".req_ready_busy"}, req_ready, 0);
    tick();
    chk({tag, ".bus_valid_drop"}, bus_valid, 0);
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] mesi,
                           input logic [1:0] snoop, input logic to);
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_mesi"}, rsp_mesi, mesi);
    chk({tag, ".rsp_snoop"}, rsp_snoop, snoop);
    chk({tag, ".rsp_timeout"}, rsp_timeout, to);
    chk({tag, ".req_ready_resp"}, req_ready, 0);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, ".rsp_valid_done"}, rsp_valid, 0);
    chk({tag, ".req_ready_idle"}, req_ready, 1);
  endtask

  task automatic strobe(input logic [N-1:0] v, input logic [1:0] p2,
                        input logic [1:0] p1, input logic [1:0] p0);
    snp_valid  = v;
    snp_result = {p2, p1, p0};
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".req_ready"}, req_ready, 1);
    chk({tag, ".bus_valid"}, bus_valid, 0);
    chk({tag, ".bus_op"}, bus_op, 0);
    chk({tag, ".bus_addr"}, bus_addr, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 0);
    chk({tag, ".rsp_mesi"}, rsp_mesi, I);
    chk({tag, ".rsp_snoop"}, rsp_snoop, NOHIT);
    chk({tag, ".rsp_timeout"}, rsp_timeout, 0);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_addr   = '0;
    snp_valid  = '0;
    snp_result = '0;
    wb_done    = 1'b0;
    rsp_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    reset_checks("reset");
    rst = 1'b0;
    tick();

    // READ, all peers NOHIT in the first COLLECT cycle -> E
    issue("t1", READ, 32'h0000_1A40);
    strobe(3'b111, NOHIT, NOHIT, NOHIT);
    chk("t1.no_rsp_yet", rsp_valid, 0);
    tick();
    strobe(3'b000, NOHIT, NOHIT, NOHIT);
    check_rsp("t1", E, NOHIT, 0);
    handshake("t1");

    // READ, staggered responses, peer0 strobes twice (second would be HITM) -> S/HIT
    issue("t2", READ, 32'h0000_2000);
    strobe(3'b001, NOHIT, NOHIT, HIT);
    tick();
    strobe(3'b001, NOHIT, NOHIT, HITM);
    tick();
    strobe(3'b010, NOHIT, NOHIT, NOHIT);
    tick();
    chk("t2.collecting", rsp_valid, 0);
    strobe(3'b100, NOHIT, NOHIT, NOHIT);
    tick();
    strobe(3'b000, NOHIT, NOHIT, NOHIT);
    check_rsp("t2", S, HIT, 0);
    handshake("t2");

    // RFO, peer1 HITM -> wait for writeback, then M/HITM
    issue("t3", RFO, 32'h0000_3000);
    strobe(3'b111, NOHIT, HITM, NOHIT);
    tick();
    strobe(3'b000, NOHIT, NOHIT, NOHIT);
    for (int k = 0; k < 5; k++) begin
      chk("t3.wait_wb", rsp_valid, 0);
      tick();
    end
    wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    check_rsp("t3", M, HITM, 0);
    handshake("t3");

    // WRITE with HITM -> no writeback wait, I; hold rsp_ready low for 4 cycles
    issue("t5", WRITE, 32'h0000_5000);
    strobe(3'b111, HITM, NOHIT, NOHIT);
    tick();
    strobe(3'b000, NOHIT, NOHIT, NOHIT);
    check_rsp("t5", I, HITM, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_rsp("t5.hold", I, HITM, 0);
    end
    handshake("t5");

    // READ, peer2 silent -> full timeout, response 8 cycles after first COLLECT
    issue("t4", READ, 32'h0000_4000);
    strobe(3'b001, NOHIT, NOHIT, HIT);
    tick();
    strobe(3'b010, NOHIT, NOHIT, NOHIT);
    tick();
    strobe(3'b000, NOHIT, NOHIT, NOHIT);
    for (int k = 2; k < TO; k++) begin
      chk("t4.collecting", rsp_valid, 0);
      tick();
    end
    check_rsp("t4", S, HIT, 1);
    handshake("t4");

    // Reset during COLLECT aborts; all outputs return to reset values at once
    issue("t6", READ, 32'h0000_6000);
    strobe(3'b001, NOHIT, NOHIT, HIT);
    tick();
    strobe(3'b000, NOHIT, NOHIT, NOHIT);
    #2;
    rst = 1'b1;
    #1;
    reset_checks("t6.abort");
    tick();
    rst = 1'b0;
    tick();
    chk("t6.no_rsp_after", rsp_valid, 0);

    // Reset during ISSUE drops the bus strobe immediately
    req_op    = RFO;
    req_addr  = 32'h0000_7000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t7.bus_valid", bus_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7.bus_valid_abort", bus_valid, 0);
    chk("t7.bus_addr_abort", bus_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    // Next request after reset proceeds normally: INVALIDATE -> M
    issue("t8", INVAL, 32'h0000_8000);
    strobe(3'b111, NOHIT, NOHIT, NOHIT);
    tick();
    strobe(3'b000, NOHIT, NOHIT, NOHIT);
    check_rsp("t8", M, NOHIT, 0);
    handshake("t8");

    // Timeout variant: peer2 answers HIT exactly on the last COLLECT cycle
    issue("t9", READ, 32'h0000_9000);
    strobe(3'b001, NOHIT, NOHIT, NOHIT);
    tick();
    strobe(3'b010, NOHIT, NOHIT, NOHIT);
    tick();
    strobe(3'b000, NOHIT, NOHIT, NOHIT);
    for (int k = 2; k < TO - 1; k++) begin
      chk("t9.collecting", rsp_valid, 0);
      tick();
    end
    strobe(3'b100, HIT, NOHIT, NOHIT);
    chk("t9.last_cycle", rsp_valid, 0);
    tick();
    strobe(3'b000, NOHIT, NOHIT, NOHIT);
    check_rsp("t9", S, HIT, 0);
    handshake("t9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
